// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU share sequencer: FSM states, flag bit
// positions, requester ids and the dual-rail agreement pattern.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StCheck,
    StResp
  } seq_state_e;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_P = 3;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  localparam logic [7:0] RAIL_OK = 8'hFF;

  // Flag units drive active-low outputs; pack them active-high in C/Z/N/P order.
  function automatic logic [3:0] unit_flags(input logic n_carry, input logic n_zero,
                                            input logic n_neg, input logic n_par);
    logic [3:0] f;
    f = '0;
    f[FLAG_C] = ~n_carry;
    f[FLAG_Z] = ~n_zero;
    f[FLAG_N] = ~n_neg;
    f[FLAG_P] = ~n_par;
    return f;
  endfunction

  function automatic logic [3:0] merge_flags(input logic [3:0] old_flags,
                                             input logic [3:0] new_flags,
                                             input logic [3:0] mask);
    return (mask & new_flags) | (~mask & old_flags);
  endfunction

endpackage

// File: rtl/alu_seq_rr_arbiter.sv
// Two-way round-robin grant; the pointer moves to the other side on every accept
// so a held tie alternates between requesters.
module alu_seq_rr_arbiter
  import alu_seq_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic valid_a_i,
  input  logic valid_b_i,
  output logic grant_a_o,
  output logic grant_b_o,
  output logic grant_id_o,
  output logic accept_o
);

  logic ptr_q;

  always_comb begin
    grant_a_o = 1'b0;
    grant_b_o = 1'b0;
    if (enable_i) begin
      if (valid_a_i && valid_b_i) begin
        grant_a_o = (ptr_q == ID_A);
        grant_b_o = (ptr_q == ID_B);
      end else begin
        grant_a_o = valid_a_i;
        grant_b_o = valid_b_i;
      end
    end
  end

  assign accept_o   = grant_a_o | grant_b_o;
  assign grant_id_o = grant_b_o ? ID_B : ID_A;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= ID_A;
    end else if (accept_o) begin
      ptr_q <= ~grant_id_o;
    end
  end

endmodule

// File: rtl/alu_share_sequencer.sv
// Time-shares one dual-rail NOR ALU and its flag units between two requesters,
// holding operands for the settle time and checking rail agreement before capture.
module alu_share_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned MAX_EXTEND    = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ReqValidA,
  input  logic       ReqValidB,
  output logic       ReqReadyA,
  output logic       ReqReadyB,
  input  logic [3:0] ReqOpA,
  input  logic [3:0] ReqOpB,
  input  logic [7:0] ReqXA,
  input  logic [7:0] ReqYA,
  input  logic [7:0] ReqXB,
  input  logic [7:0] ReqYB,
  input  logic [3:0] ReqFlagWeA,
  input  logic [3:0] ReqFlagWeB,
  output logic [3:0] AluOp,
  output logic [7:0] AluX,
  output logic [7:0] AluY,
  output logic       AluCin,
  input  logic [7:0] Result,
  input  logic [7:0] notResult,
  input  logic       notCarryOut,
  input  logic       notIsZero,
  input  logic       notIsNegative,
  input  logic       notIs8bitEvenParity,
  output logic       RespValidA,
  output logic       RespValidB,
  input  logic       RespReadyA,
  input  logic       RespReadyB,
  output logic [7:0] RespData,
  output logic [3:0] RespFlags,
  output logic [3:0] Flags,
  output logic       RailFault,
  output logic       Busy
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int unsigned ExtW = (MAX_EXTEND > 1) ? $clog2(MAX_EXTEND + 1) : 1;

  seq_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic [ExtW-1:0] ext_q;
  logic            id_q;
  logic [3:0]      mask_q;

  logic grant_a, grant_b, grant_id, accept;
  logic rails_ok, resp_ready_sel;
  logic [3:0] new_flags;

  // Reset gates the grant so no request is accepted on the reset edge.
  alu_seq_rr_arbiter u_arbiter (
    .clk_i      (CLK),
    .rst_i      (RST),
    .enable_i   ((state_q == StIdle) && !RST),
    .valid_a_i  (ReqValidA),
    .valid_b_i  (ReqValidB),
    .grant_a_o  (grant_a),
    .grant_b_o  (grant_b),
    .grant_id_o (grant_id),
    .accept_o   (accept)
  );

  assign ReqReadyA = grant_a;
  assign ReqReadyB = grant_b;

  assign rails_ok       = ((Result ^ notResult) == RAIL_OK);
  assign new_flags      = unit_flags(notCarryOut, notIsZero, notIsNegative, notIs8bitEvenParity);
  assign resp_ready_sel = (id_q == ID_B) ? RespReadyB : RespReadyA;

  assign RespValidA = (state_q == StResp) && (id_q == ID_A);
  assign RespValidB = (state_q == StResp) && (id_q == ID_B);
  assign Busy       = (state_q != StIdle);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ext_q     <= '0;
      id_q      <= ID_A;
      mask_q    <= '0;
      AluOp     <= '0;
      AluX      <= '0;
      AluY      <= '0;
      AluCin    <= 1'b0;
      RespData  <= '0;
      RespFlags <= '0;
      Flags     <= '0;
      RailFault <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            id_q    <= grant_id;
            AluOp   <= (grant_id == ID_B) ? ReqOpB : ReqOpA;
            AluX    <= (grant_id == ID_B) ? ReqXB : ReqXA;
            AluY    <= (grant_id == ID_B) ? ReqYB : ReqYA;
            mask_q  <= (grant_id == ID_B) ? ReqFlagWeB : ReqFlagWeA;
            AluCin  <= Flags[FLAG_C];
            cnt_q   <= CntW'(SETTLE_CYCLES);
            ext_q   <= '0;
            state_q <= StSettle;
          end
        end
        StSettle: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= StCheck;
          end
        end
        StCheck: begin
          // After the extension budget is spent, capture whatever the rails show.
          if (rails_ok || (ext_q == ExtW'(MAX_EXTEND))) begin
            RespData  <= Result;
            RespFlags <= new_flags;
            Flags     <= merge_flags(Flags, new_flags, mask_q);
            if (!rails_ok) begin
              RailFault <= 1'b1;
            end
            state_q <= StResp;
          end else begin
            ext_q <= ext_q + ExtW'(1);
          end
        end
        StResp: begin
          if (resp_ready_sel) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_sequencer.sv
// Directed bench for alu_share_sequencer: a transaction-timeline model checked every
// cycle, plus literal expectations for latency, flag masking, rail faults and reset.
module tb_alu_share_sequencer;

  localparam int unsigned S    = 3;
  localparam int unsigned MAXE = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ReqValidA, ReqValidB, ReqReadyA, ReqReadyB;
  logic [3:0] ReqOpA, ReqOpB, ReqFlagWeA, ReqFlagWeB;
  logic [7:0] ReqXA, ReqYA, ReqXB, ReqYB;
  logic [3:0] AluOp;
  logic [7:0] AluX, AluY;
  logic       AluCin;
  logic [7:0] Result, notResult;
  logic       notCarryOut, notIsZero, notIsNegative, notIs8bitEvenParity;
  logic       RespValidA, RespValidB, RespReadyA, RespReadyB;
  logic [7:0] RespData;
  logic [3:0] RespFlags, Flags;
  logic       RailFault, Busy;

  alu_share_sequencer #(.SETTLE_CYCLES(S), .MAX_EXTEND(MAXE)) dut (
    .CLK(CLK), .RST(RST),
    .ReqValidA(ReqValidA), .ReqValidB(ReqValidB),
    .ReqReadyA(ReqReadyA), .ReqReadyB(ReqReadyB),
    .ReqOpA(ReqOpA), .ReqOpB(ReqOpB),
    .ReqXA(ReqXA), .ReqYA(ReqYA), .ReqXB(ReqXB), .ReqYB(ReqYB),
    .ReqFlagWeA(ReqFlagWeA), .ReqFlagWeB(ReqFlagWeB),
    .AluOp(AluOp), .AluX(AluX), .AluY(AluY), .AluCin(AluCin),
    .Result(Result), .notResult(notResult),
    .notCarryOut(notCarryOut), .notIsZero(notIsZero),
    .notIsNegative(notIsNegative), .notIs8bitEvenParity(notIs8bitEvenParity),
    .RespValidA(RespValidA), .RespValidB(RespValidB),
    .RespReadyA(RespReadyA), .RespReadyB(RespReadyB),
    .RespData(RespData), .RespFlags(RespFlags), .Flags(Flags),
    .RailFault(RailFault), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one transaction at a time, tracked as a timeline from its accept cycle.
  int         cyc = 0;
  int         m_t0 = 0;
  bit         m_on = 0, m_active = 0, m_resp = 0, m_ptr = 0, m_id = 0, m_fault = 0;
  logic       m_cin = 0;
  logic [3:0] m_op = 0, m_mask = 0, m_flags = 0, m_rflags = 0;
  logic [7:0] m_x = 0, m_y = 0, m_data = 0;

  always @(posedge CLK) begin
    if (RST) begin
      m_on = 1; m_active = 0; m_resp = 0; m_ptr = 0; m_id = 0; m_fault = 0;
      m_cin = 0; m_op = 0; m_mask = 0; m_flags = 0; m_rflags = 0;
      m_x = 0; m_y = 0; m_data = 0;
    end else if (!m_active) begin
      if (ReqValidA || ReqValidB) begin
        m_id   = (ReqValidA && ReqValidB) ? m_ptr : ReqValidB;
        m_op   = m_id ? ReqOpB : ReqOpA;
        m_x    = m_id ? ReqXB : ReqXA;
        m_y    = m_id ? ReqYB : ReqYA;
        m_mask = m_id ? ReqFlagWeB : ReqFlagWeA;
        m_cin  = m_flags[0];
        m_ptr  = !m_id;
        m_active = 1;
        m_t0   = cyc;
      end
    end else if (!m_resp) begin
      if (cyc >= m_t0 + int'(S) + 1) begin
        if ((Result ^ notResult) == 8'hFF || cyc - (m_t0 + int'(S) + 1) == int'(MAXE)) begin
          if ((Result ^ notResult) != 8'hFF) m_fault = 1;
          m_data   = Result;
          m_rflags = {~notIs8bitEvenParity, ~notIsNegative, ~notIsZero, ~notCarryOut};
          for (int i = 0; i < 4; i++) if (m_mask[i]) m_flags[i] = m_rflags[i];
          m_resp = 1;
        end
      end
    end else if (m_id ? RespReadyB : RespReadyA) begin
      m_active = 0;
      m_resp   = 0;
    end
    cyc++;
  end

  always @(negedge CLK) begin
    if (m_on && !RST) begin
      chk("ReqReadyA", ReqReadyA, !m_active && ReqValidA && (!ReqValidB || !m_ptr));
      chk("ReqReadyB", ReqReadyB, !m_active && ReqValidB && (!ReqValidA || m_ptr));
      chk("Busy", Busy, m_active);
      chk("RespValidA", RespValidA, m_resp && !m_id);
      chk("RespValidB", RespValidB, m_resp && m_id);
      chk("RespData", RespData, m_data);
      chk("RespFlags", RespFlags, m_rflags);
      chk("Flags", Flags, m_flags);
      chk("RailFault", RailFault, m_fault);
      chk("AluOp", AluOp, m_op);
      chk("AluX", AluX, m_x);
      chk("AluY", AluY, m_y);
      chk("AluCin", AluCin, m_cin);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  // Drives one request, plays the ALU (rails wrong on bit 3 for `bad` CHECK cycles),
  // holds RespReady low for `stall` cycles after RespValid, then completes it.
  task automatic run_op(input bit side, input logic [3:0] op, input logic [7:0] x,
                        input logic [7:0] y, input logic [3:0] mask, input logic [7:0] res,
                        input logic [3:0] fl, input int bad, input int stall,
                        input bit poke_b, output int lat);
    bit acc;
    Result    = res;
    notResult = ~res ^ ((bad > 0) ? 8'h08 : 8'h00);
    {notIs8bitEvenParity, notIsNegative, notIsZero, notCarryOut} = ~fl;
    if (side) begin
      ReqValidB = 1; ReqOpB = op; ReqXB = x; ReqYB = y; ReqFlagWeB = mask;
    end else begin
      ReqValidA = 1; ReqOpA = op; ReqXA = x; ReqYA = y; ReqFlagWeA = mask;
    end
    acc = 0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge CLK);
      acc = side ? ReqReadyB : ReqReadyA;
      tick();
    end
    ReqValidA = 0;
    ReqValidB = 0;
    lat = -1;
    chk("accept_seen", acc, 1);
    if (!acc) return;
    for (int k = 1; k < 40; k++) begin
      if (k == int'(S) + 1 + bad) notResult = ~res;
      @(negedge CLK);
      if (side ? RespValidB : RespValidA) begin
        lat = k;
        break;
      end
      tick();
    end
    chk("resp_seen", (lat > 0), 1);
    if (lat < 0) return;
    chk("resp_data_lit", RespData, res);
    chk("resp_flags_lit", RespFlags, fl);
    for (int j = 0; j < stall; j++) begin
      tick();
      if (poke_b) ReqValidB = 1;
      @(negedge CLK);
      chk("stall_valid", side ? RespValidB : RespValidA, 1);
      chk("stall_data", RespData, res);
      chk("stall_flags", RespFlags, fl);
      chk("stall_readyA", ReqReadyA, 0);
      chk("stall_readyB", ReqReadyB, 0);
      chk("stall_busy", Busy, 1);
    end
    tick();
    ReqValidB = 0;
    if (side) RespReadyB = 1; else RespReadyA = 1;
    tick();
    RespReadyA = 0;
    RespReadyB = 0;
    notResult = ~res;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acc_id[$];
    int acc_cyc[$];
    RST = 1; ReqValidA = 0; ReqValidB = 0; RespReadyA = 0; RespReadyB = 0;
    ReqOpA = 0; ReqOpB = 0; ReqXA = 0; ReqYA = 0; ReqXB = 0; ReqYB = 0;
    ReqFlagWeA = 0; ReqFlagWeB = 0; Result = 0; notResult = 8'hFF;
    notCarryOut = 1; notIsZero = 1; notIsNegative = 1; notIs8bitEvenParity = 1;
    @(posedge CLK);
    #1;
    do_reset();

    // 1: basic A op, latency and flags
    @(negedge CLK);
    chk("reset_flags", Flags, 0);
    chk("reset_busy", Busy, 0);
    tick();
    run_op(0, 4'h3, 8'h0F, 8'h01, 4'hF, 8'h10, 4'h0, 0, 0, 0, lat);
    chk("t1_latency", lat, 5);
    @(negedge CLK);
    chk("t1_flags", Flags, 4'h0);
    tick();

    // 2: held tie alternates A, B, A at one op per S+3 cycles
    do_reset();
    ReqValidA = 1; ReqValidB = 1; RespReadyA = 1; RespReadyB = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (ReqValidA && ReqReadyA) begin acc_id.push_back(0); acc_cyc.push_back(k); end
      if (ReqValidB && ReqReadyB) begin acc_id.push_back(1); acc_cyc.push_back(k); end
      tick();
    end
    ReqValidA = 0; ReqValidB = 0;
    repeat (10) tick();
    RespReadyA = 0; RespReadyB = 0;
    chk("t2_count", (acc_id.size() >= 3), 1);
    if (acc_id.size() >= 3) begin
      chk("t2_first", acc_id[0], 0);
      chk("t2_second", acc_id[1], 1);
      chk("t2_third", acc_id[2], 0);
      chk("t2_period", acc_cyc[1] - acc_cyc[0], S + 3);
    end

    // 3: flag mask behaviour
    run_op(0, 4'h1, 8'h80, 8'h00, 4'hF, 8'h80, 4'hF, 0, 0, 0, lat);
    @(negedge CLK); chk("t3_preload", Flags, 4'hF); tick();
    run_op(1, 4'h2, 8'h00, 8'h00, 4'h2, 8'h00, 4'hA, 0, 0, 0, lat);
    @(negedge CLK); chk("t3_mask2", Flags, 4'hF); tick();
    run_op(0, 4'h2, 8'h01, 8'h02, 4'h1, 8'h03, 4'h0, 0, 0, 0, lat);
    @(negedge CLK); chk("t3_mask1", Flags, 4'hE); tick();

    // 4: rail disagreement, recovered then permanent
    run_op(1, 4'h4, 8'h55, 8'hAA, 4'h0, 8'h5A, 4'h8, 2, 0, 0, lat);
    chk("t4_ext_latency", lat, 7);
    @(negedge CLK); chk("t4_nofault", RailFault, 0); tick();
    run_op(0, 4'h5, 8'h12, 8'h34, 4'h0, 8'h46, 4'h0, 100, 0, 0, lat);
    chk("t4_fault_latency", lat, S + 2 + MAXE);
    @(negedge CLK); chk("t4_fault", RailFault, 1); tick();

    // 5: response back-pressure with a competing request
    run_op(0, 4'h6, 8'h21, 8'h43, 4'h4, 8'hC3, 4'h4, 0, 5, 1, lat);
    chk("t5_latency", lat, 5);

    // 6: reset during SETTLE abandons the op
    ReqValidA = 1; ReqXA = 8'h77; ReqFlagWeA = 4'hF;
    tick();
    ReqValidA = 0;
    tick();
    RST = 1;
    tick();
    RST = 0;
    @(negedge CLK);
    chk("t6_busy", Busy, 0);
    chk("t6_flags", Flags, 0);
    chk("t6_fault", RailFault, 0);
    chk("t6_alux", AluX, 0);
    chk("t6_respdata", RespData, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      @(negedge CLK);
      chk("t6_no_resp", RespValidA | RespValidB, 0);
    end
    tick();
    ReqValidA = 1; ReqValidB = 1;
    @(negedge CLK);
    chk("t6_tie_a", ReqReadyA, 1);
    chk("t6_tie_b", ReqReadyB, 0);
    tick();
    ReqValidA = 0; ReqValidB = 0; RespReadyA = 1;
    repeat (10) tick();
    RespReadyA = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_share_sequencer.md
Name: alu_share_sequencer

Overview:
Time-shares the single 8-bit NOR-gate ALU and its dual-rail flag units between two requesters. Requester A is the execute stage; requester B is address/auxiliary arithmetic. The block arbitrates round-robin and holds the operands stable for the ripple settle time. It checks that Result and notResult are complementary, captures the result and flags, updates the architectural flag register under a per-request mask, and returns the response through a valid/ready handshake. It sits between the decode/execute control and the ALU plus the ALU_flag_* units.

Parameters:
SETTLE_CYCLES, 3, cycles the ALU inputs are held before the first capture attempt (>=1)
MAX_EXTEND, 4, extra CHECK cycles allowed for rail disagreement before a fault is declared (>=1)

Ports:
CLK  in  1  sole clock, rising edge
RST  in  1  reset, synchronous, active-high
ReqValidA / ReqValidB  in  1  request valid
ReqReadyA / ReqReadyB  out  1  request accepted this cycle when valid&ready
ReqOpA / ReqOpB  in  4  ALU opcode, passed through opaque
ReqXA, ReqYA / ReqXB, ReqYB  in  8  operands
ReqFlagWeA / ReqFlagWeB  in  4  flag write mask: bit0 C, bit1 Z, bit2 N, bit3 P
AluOp  out  4  registered opcode to ALU
AluX, AluY  out  8  registered operands to ALU
AluCin  out  1  Flags[0] sampled at acceptance
Result, notResult  in  8  dual-rail ALU result
notCarryOut, notIsZero, notIsNegative, notIs8bitEvenParity  in  1  active-low flag-unit outputs
RespValidA / RespValidB  out  1  response valid
RespReadyA / RespReadyB  in  1  response consumed
RespData  out  8  captured Result
RespFlags  out  4  flags computed for this op, unmasked
Flags  out  4  architectural flag register
RailFault  out  1  sticky, set on unresolved rail disagreement
Busy  out  1  state != IDLE

Behaviour:
- Reset, synchronous on CLK with RST high:
  - state IDLE; RR pointer = A.
  - Every output is 0: AluOp/X/Y/Cin, RespData, RespFlags, Flags, RailFault, RespValid*, ReqReady*, Busy.
- States: IDLE -> SETTLE -> CHECK -> RESP -> IDLE.
- IDLE:
  - grant = the sole valid requester; on a tie, the RR pointer side.
  - ReqReady is high only for the granted side, combinational from ReqValid and the pointer.
  - On accept: latch op, X, Y, mask, id and AluCin=Flags[0]; cnt=SETTLE_CYCLES; pointer = the other side; go SETTLE.
- SETTLE:
  - ALU inputs constant; cnt decrements each cycle.
  - Go CHECK on the edge where cnt==1, so SETTLE lasts exactly SETTLE_CYCLES cycles.
- CHECK:
  - rails_ok = (Result XOR notResult) == 8'hFF.
  - If ok: RespData=Result; RespFlags = {~notIs8bitEvenParity, ~notIsNegative, ~notIsZero, ~notCarryOut}; Flags[i] = mask[i] ? RespFlags[i] : Flags[i]; go RESP.
  - If not ok and ext < MAX_EXTEND: ext++, stay in CHECK.
  - If not ok and ext == MAX_EXTEND: set RailFault; capture anyway with the same update rules; go RESP.
  - ext is cleared on accept.
- RESP:
  - RespValid is high for the granted id only.
  - RespData and RespFlags are held stable until the matching RespReady; then go IDLE next cycle.
  - ReqReady* = 0 in every non-IDLE state.
- Latency, no extension: accept in cycle 0 -> RespValid first high in cycle SETTLE_CYCLES+2 (cycle 5 at the defaults). Each extension cycle adds 1.
- Throughput: one op per SETTLE_CYCLES+3 cycles when RespReady is held high.
- A mask of 0 leaves Flags unchanged; RespFlags still reports the computed flags.
- RailFault clears only on RST.
- RST mid-operation: the operation is abandoned, no response is issued, Flags=0.
- Requester inputs are ignored outside IDLE.

Decomposition:
- Shared package alu_seq_pkg:
  - state enum (IDLE, SETTLE, CHECK, RESP)
  - flag bit indices FLAG_C=0, FLAG_Z=1, FLAG_N=2, FLAG_P=3
  - requester id encoding (A=0, B=1)
  - constant RAIL_OK=8'hFF
- One sub-module: alu_seq_rr_arbiter. It is a 2-way round-robin grant with pointer update on accept.

Test Plan:
1. Request A, X=0x0F, Y=0x01, mask 0xF; ALU model returns Result=0x10, notResult=0xEF, carry 0 -> RespValidA in cycle 5; RespData=0x10; RespFlags=0x0; Flags=0x0.
2. After reset, A and B both valid and held valid -> A accepted first, then B; next tie grants A; ReqReady never high in a non-IDLE state.
3. Flags=0xF preloaded; B op with mask 0x2 and Result=0x00 (Z=1, P=1, others 0) -> Flags=0xF. Then mask 0x1 with carry 0 -> Flags=0xE.
4. Result bit3 equal on both rails for 2 CHECK cycles, then corrected -> RespValid delayed 2 cycles; RailFault=0. Disagreement held permanently with MAX_EXTEND=4 -> RailFault=1 after 4 extension cycles and the response is still issued.
5. RespReadyA held low for 5 cycles in RESP -> RespValidA, RespData and RespFlags stable; ReqReadyA/B=0; Busy=1.
6. RST pulsed during SETTLE -> next cycle all outputs 0, no RespValid, state IDLE, tie grant returns to A.
